// File: rtl/rr_mux_reg.sv
// Registered CHANNELS:1 word multiplexer with fixed or round-robin selection and a valid/ready output stage.
// Optional RR_MUX_PARITY_EN adds a registered even-parity bit (out_par) for the captured word.
module rr_mux_reg #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch
`ifdef RR_MUX_PARITY_EN
    ,
    output logic                      out_par
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             load;
    logic             grant;
    logic [SEL_W-1:0] g;
    logic [WIDTH-1:0] word;

    assign load = ~out_valid_q | out_ready;

    // Grant: fixed compares sel against each legal index, so sel >= CHANNELS never matches.
    // Round-robin searches channels at/above ptr first, then wraps to the low channels.
    always_comb begin
        grant = 1'b0;
        g     = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!grant && in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
                    grant = 1'b1;
                    g     = SEL_W'(i);
                end
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!grant && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        word     = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (g == SEL_W'(i)) begin
                word        = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load & grant;
            end
        end
    end

    // Next state: loading with no grant empties the register but keeps data/channel.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant;
            if (grant) begin
                out_data_d = word;
                out_ch_d   = g;
                if (mode) begin
                    ptr_d = (32'(g) == CHANNELS - 1) ? '0 : g + SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef RR_MUX_PARITY_EN
    logic out_par_q, out_par_d;

    always_comb begin
        out_par_d = out_par_q;
        if (load && grant) begin
            out_par_d = ^word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg: 4-channel and 3-channel instances, parity instance when RR_MUX_PARITY_EN is defined.
module tb_rr_mux_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0] a_data;
    logic [3:0] a_valid, a_ready;
    logic       a_mode, a_ov, a_or;
    logic [1:0] a_sel, a_od, a_och;

    logic [5:0] b_data;
    logic [2:0] b_valid, b_ready;
    logic       b_mode, b_ov, b_or;
    logic [1:0] b_sel, b_od, b_och;

`ifdef RR_MUX_PARITY_EN
    logic        a_par, b_par, p_par;
    logic [15:0] p_data;
    logic [3:0]  p_valid, p_ready, p_od;
    logic        p_mode, p_ov, p_or;
    logic [1:0]  p_sel, p_och;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         a_ptr, b_ptr;
    bit         a_ov_m, b_ov_m;
    logic [3:0] a_last, b_last;
    logic [3:0] a_q[$];
    logic [3:0] b_q[$];

    rr_mux_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .mode(a_mode), .sel(a_sel), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_ch(a_och)
`ifdef RR_MUX_PARITY_EN
        , .out_par(a_par)
`endif
    );

    rr_mux_reg #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .mode(b_mode), .sel(b_sel), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_ch(b_och)
`ifdef RR_MUX_PARITY_EN
        , .out_par(b_par)
`endif
    );

`ifdef RR_MUX_PARITY_EN
    rr_mux_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_data(p_data), .in_valid(p_valid), .in_ready(p_ready),
        .mode(p_mode), .sel(p_sel), .out_valid(p_ov), .out_ready(p_or), .out_data(p_od), .out_ch(p_och),
        .out_par(p_par)
    );
`endif

    always #5 clk = ~clk;

    // Rotating-search grant model
    function automatic void model_grant(input int n, input bit md, input int s, input logic [3:0] v,
                                        input int p, output bit found, output int g);
        found = 1'b0;
        g = 0;
        if (!md) begin
            if (s < n && v[s] === 1'b1) begin
                found = 1'b1;
                g = s;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (p + k) % n;
                if (!found && v[i] === 1'b1) begin
                    found = 1'b1;
                    g = i;
                end
            end
        end
    endfunction

    task automatic reset_models();
        a_ptr = 0; b_ptr = 0;
        a_ov_m = 1'b0; b_ov_m = 1'b0;
        a_last = 4'h0; b_last = 4'h0;
        a_q.delete(); b_q.delete();
    endtask

    // One cycle on dut_a: sample in_ready, predict, clock, sample outputs
    task automatic step_a(output logic [3:0] rdy_obs, output logic [3:0] rdy_exp, output logic ov_obs,
                          output logic ov_exp, output logic [3:0] out_obs, output logic [3:0] out_exp);
        bit load, found;
        int g;
        #1;
        load = !a_ov_m || a_or;
        model_grant(4, a_mode, int'(a_sel), a_valid, a_ptr, found, g);
        rdy_obs = a_ready;
        rdy_exp = (load && found) ? 4'(1 << g) : 4'b0;
        if (load) begin
            a_ov_m = found;
            if (found) begin
                a_q.push_back({2'(g), a_data[g*2 +: 2]});
                if (a_mode) a_ptr = (g == 3) ? 0 : g + 1;
            end
        end
        @(posedge clk);
        #1;
        ov_obs = a_ov;
        out_obs = {a_och, a_od};
        if (load && found) a_last = a_q.pop_front();
        out_exp = a_last;
        ov_exp = a_ov_m;
    endtask

    task automatic step_b(output logic [3:0] rdy_obs, output logic [3:0] rdy_exp, output logic ov_obs,
                          output logic ov_exp, output logic [3:0] out_obs, output logic [3:0] out_exp);
        bit load, found;
        int g;
        #1;
        load = !b_ov_m || b_or;
        model_grant(3, b_mode, int'(b_sel), {1'b0, b_valid}, b_ptr, found, g);
        rdy_obs = {1'b0, b_ready};
        rdy_exp = (load && found) ? 4'(1 << g) : 4'b0;
        if (load) begin
            b_ov_m = found;
            if (found) begin
                b_q.push_back({2'(g), b_data[g*2 +: 2]});
                if (b_mode) b_ptr = (g == 2) ? 0 : g + 1;
            end
        end
        @(posedge clk);
        #1;
        ov_obs = b_ov;
        out_obs = {b_och, b_od};
        if (load && found) b_last = b_q.pop_front();
        out_exp = b_last;
        ov_exp = b_ov_m;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_ov, a_och, a_od} !== 5'b0) begin
            failures++;
            $display("FAIL reset_a got ov=%b ch=%0d data=%b exp all 0", a_ov, a_och, a_od);
        end
        checks++;
        if ({b_ov, b_och, b_od} !== 5'b0) begin
            failures++;
            $display("FAIL reset_b got ov=%b ch=%0d data=%b exp all 0", b_ov, b_och, b_od);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        logic [3:0] ro, re, oo, oe;
        logic vo, ve;
        a_mode = 1'b0; a_sel = 2'd2; a_data = 8'b11_10_01_00; a_valid = 4'b1111; a_or = 1'b1;
        step_a(ro, re, vo, ve, oo, oe);
        checks++;
        if (ro !== 4'b0100) begin
            failures++;
            $display("FAIL fixed_ready got=%b exp=0100", ro);
        end
        checks++;
        if (vo !== 1'b1 || oo !== {2'd2, 2'b10}) begin
            failures++;
            $display("FAIL fixed_out got ov=%b ch_data=%b exp ov=1 ch_data=1010", vo, oo);
        end
        a_sel = 2'd3; a_valid = 4'b0111;
        step_a(ro, re, vo, ve, oo, oe);
        checks++;
        if (ro !== re || vo !== ve || oo !== oe) begin
            failures++;
            $display("FAIL fixed_nogrant got rdy=%b ov=%b out=%b exp rdy=%b ov=%b out=%b", ro, vo, oo, re, ve, oe);
        end
        a_sel = 2'd1; a_valid = 4'b1111;
        step_a(ro, re, vo, ve, oo, oe);
        checks++;
        if (ro !== re || vo !== ve || oo !== oe) begin
            failures++;
            $display("FAIL fixed_sel1 got rdy=%b ov=%b out=%b exp rdy=%b ov=%b out=%b", ro, vo, oo, re, ve, oe);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ro, re, oo, oe;
        logic vo, ve;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ov, a_och, a_od} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid got ov=%b ch=%0d data=%b exp all 0", a_ov, a_och, a_od);
        end
        reset_models();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_mode = 1'b1; a_valid = 4'b1111; a_or = 1'b1; a_data = 8'($urandom);
        step_a(ro, re, vo, ve, oo, oe);
        checks++;
        if (vo !== 1'b1 || oo[3:2] !== 2'd0 || oo !== oe) begin
            failures++;
            $display("FAIL reset_first_rr got ov=%b out=%b exp ov=1 out=%b", vo, oo, oe);
        end
    endtask

    task automatic test_rr();
        logic [3:0] ro, re, oo, oe;
        logic vo, ve;
        int exp_ch[6] = '{0, 1, 3, 0, 1, 3};
        a_mode = 1'b1; a_or = 1'b1; a_valid = 4'b1000; a_data = 8'($urandom);
        step_a(ro, re, vo, ve, oo, oe);
        a_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            a_data = 8'($urandom);
            step_a(ro, re, vo, ve, oo, oe);
            checks++;
            if (ro !== re || vo !== 1'b1 || oo !== oe || int'(oo[3:2]) != exp_ch[k]) begin
                failures++;
                $display("FAIL rr_seq[%0d] got rdy=%b ov=%b out=%b exp rdy=%b ch=%0d out=%b",
                         k, ro, vo, oo, re, exp_ch[k], oe);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ro, re, oo, oe;
        logic vo, ve;
        logic orq[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        a_mode = 1'b1; a_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            a_or = orq[k];
            a_data = 8'($urandom);
            step_a(ro, re, vo, ve, oo, oe);
            checks++;
            if (ro !== re || vo !== ve || oo !== oe) begin
                failures++;
                $display("FAIL bp[%0d] got rdy=%b ov=%b out=%b exp rdy=%b ov=%b out=%b", k, ro, vo, oo, re, ve, oe);
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if (ro !== 4'b0 || oo[3:2] !== 2'd1 || vo !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold[%0d] got rdy=%b ov=%b ch=%0d exp rdy=0000 ov=1 ch=1", k, ro, vo, oo[3:2]);
                end
            end
        end
        checks++;
        if (vo !== 1'b1 || oo[3:2] !== 2'd3) begin
            failures++;
            $display("FAIL bp_release got ov=%b ch=%0d exp ov=1 ch=3", vo, oo[3:2]);
        end
        a_valid = 4'b0000;
        step_a(ro, re, vo, ve, oo, oe);
        checks++;
        if (vo !== 1'b0 || oo !== oe) begin
            failures++;
            $display("FAIL drain got ov=%b out=%b exp ov=0 out=%b", vo, oo, oe);
        end
    endtask

    task automatic test_random();
        logic [3:0] ro, re, oo, oe;
        logic vo, ve;
        for (int k = 0; k < 60; k++) begin
            a_mode  = 1'($urandom);
            a_sel   = 2'($urandom);
            a_valid = 4'($urandom);
            a_or    = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom);
            step_a(ro, re, vo, ve, oo, oe);
            checks++;
            if (ro !== re || vo !== ve || oo !== oe) begin
                failures++;
                $display("FAIL rand[%0d] got rdy=%b ov=%b out=%b exp rdy=%b ov=%b out=%b", k, ro, vo, oo, re, ve, oe);
            end
        end
    endtask

    task automatic test_np2();
        logic [3:0] ro, re, oo, oe;
        logic vo, ve;
        int exp_ch[4] = '{0, 1, 2, 0};
        b_mode = 1'b1; b_valid = 3'b111; b_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_data = 6'($urandom);
            step_b(ro, re, vo, ve, oo, oe);
            checks++;
            if (ro !== re || vo !== 1'b1 || oo !== oe || int'(oo[3:2]) != exp_ch[k]) begin
                failures++;
                $display("FAIL np2_seq[%0d] got rdy=%b ov=%b out=%b exp rdy=%b ch=%0d out=%b",
                         k, ro, vo, oo, re, exp_ch[k], oe);
            end
        end
        b_mode = 1'b0; b_sel = 2'd3;
        step_b(ro, re, vo, ve, oo, oe);
        checks++;
        if (ro !== 4'b0 || vo !== 1'b0 || oo !== oe) begin
            failures++;
            $display("FAIL np2_sel3 got rdy=%b ov=%b out=%b exp rdy=0000 ov=0 out=%b", ro, vo, oo, oe);
        end
    endtask

`ifdef RR_MUX_PARITY_EN
    task automatic test_parity();
        logic [3:0] w;
        logic [3:0] words[2] = '{4'b1011, 4'b1001};
        logic       exp_par[2] = '{1'b1, 1'b0};
        p_mode = 1'b0; p_sel = 2'd0; p_valid = 4'b0001; p_or = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            p_data = {12'h0, w};
            @(posedge clk);
            #1;
            checks++;
            if (p_par !== exp_par[k] || p_od !== w) begin
                failures++;
                $display("FAIL parity[%0d] got par=%b data=%b exp par=%b data=%b", k, p_par, p_od, exp_par[k], w);
            end
        end
    endtask
`endif

    initial begin
        a_data = '0; a_valid = '0; a_mode = 1'b0; a_sel = '0; a_or = 1'b0;
        b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = '0; b_or = 1'b1;
`ifdef RR_MUX_PARITY_EN
        p_data = '0; p_valid = '0; p_mode = 1'b0; p_sel = '0; p_or = 1'b1;
`endif
        reset_models();
        test_reset();
        test_fixed();
        test_reset_mid();
        test_rr();
        test_backpressure();
        test_random();
        test_np2();
`ifdef RR_MUX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
